wts_channel_register: RTL
=========================

Name: wts_channel_register

Overview:
Parametrised control-register file for the wave-table sound engine. It holds per-channel frequency count, volume and enable for CH_NUM channels, plus a global mode register. The CPU side uses a simple wrreq/rdreq byte bus. The tone-generator side is fed by a free-running, time-multiplexed channel scan. New in this generation:
- configurable channel count and field widths;
- atomic (shadowed) frequency update;
- per-channel phase-reset pulses;
- registered read-back with a valid strobe.

Parameters:
CH_NUM, 5, number of channels; legal 1..8.
FREQ_W, 12, frequency count width; legal 9..16.
VOL_W, 4, volume width; legal 1..8.

Ports:
nreset  input  1  asynchronous reset, active low
clk  input  1  clock
wrreq  input  1  single-cycle write strobe
rdreq  input  1  single-cycle read strobe
address  input  8  register address
wrdata  input  8  write data
rddata  output  8  read data, valid when rdvalid=1
rdvalid  output  1  one-cycle pulse, the cycle after rdreq
scan_en  input  1  advance channel scan
scan_valid  output  1  scan outputs updated this cycle
scan_ch  output  3  channel index of scan outputs
scan_frequency  output  FREQ_W  frequency of scan_ch
scan_volume  output  VOL_W  volume of scan_ch
scan_enable  output  1  enable bit of scan_ch
scan_first  output  1  scan_ch==0 while scan_valid=1
phase_reset  output  CH_NUM  per-channel one-cycle phase-reset pulse

Behaviour:
- Reset is nreset, asynchronous, active-low; clock is clk; all state is clocked on the rising edge of clk.
- Reset values: all frequencies, volumes, shadows, enable mask, mode, scan counter, rddata = 0; rdvalid, scan_valid, scan_first, phase_reset = 0; scan_ch, scan_frequency, scan_volume, scan_enable = 0.
- Address map for channel c < CH_NUM:
  - 0x00+2c: frequency low byte [7:0].
  - 0x01+2c: frequency high bits [FREQ_W-1:8], taken from wrdata[FREQ_W-9:0]; upper wrdata bits ignored.
  - 0x10+c: volume, from wrdata[VOL_W-1:0].
  - 0x18: enable mask; bit c enables channel c; bits >= CH_NUM ignored.
  - 0x1F: mode register. bit0 = ATOMIC; bit1 = PRST (phase reset on frequency commit); other bits read 0.
  - Any other address, including addresses of channels >= CH_NUM: write ignored, read 0xFF.
- Frequency write, ATOMIC=0: each byte write updates the committed frequency directly, next cycle.
- Frequency write, ATOMIC=1:
  - A low-byte write goes only into the per-channel shadow.
  - A high-byte write commits {wrdata high bits, shadow} in one edge.
  - The shadow persists until overwritten; it is never cleared by a commit.
- Changing ATOMIC does not flush the shadows.
- Phase reset: when PRST=1, phase_reset[c] pulses for exactly 1 cycle, on the cycle after any commit to channel c's frequency (either byte when ATOMIC=0, high byte only when ATOMIC=1). When PRST=0, no pulse.
- Read path:
  - rdreq at cycle N gives rddata and rdvalid=1 at cycle N+1.
  - rddata holds its value afterwards; rdvalid is 0 otherwise.
  - A low-byte read returns the committed low byte, never the shadow.
  - A high-byte read is zero-extended.
  - Reading the enable mask returns bits >= CH_NUM as 0.
- Simultaneous wrreq and rdreq to the same address: the write happens, and the read returns the pre-write value.
- Scan:
  - Internal counter ch_cnt in 0..CH_NUM-1.
  - When scan_en=1 at an edge: scan_ch <= ch_cnt, the scan outputs <= the committed values of ch_cnt, scan_valid <= 1, scan_first <= (ch_cnt==0). ch_cnt then increments, wrapping from CH_NUM-1 to 0.
  - When scan_en=0: ch_cnt holds, scan_valid=0, scan_first=0, data outputs hold.
  - When CH_NUM=1, ch_cnt stays 0.
- Write/scan collision: if a commit to channel c lands on the same edge that scans c, the scan presents the old value. The new value appears on the next visit to c.
- Reset mid-operation: all state returns to reset values immediately. A pending read produces no rdvalid. Pending phase_reset pulses are dropped.

Test Plan:
- Reset, then read every defined address → rddata 0x00 and rdvalid one cycle after each rdreq. Read 0x1E → 0xFF.
- ATOMIC=1 (write 0x1F=0x01). Write 0x02=0x34, then read 0x02 → 0x00. Write 0x03=0xA5 → next cycle the committed channel-1 frequency is 0x534 (FREQ_W=12).
- PRST=1 and ATOMIC=0. Write 0x04=0x10 → phase_reset=5'b00100 for exactly 1 cycle. Repeat with PRST=0 → no pulse.
- Hold scan_en=1 continuously for CH_NUM=5 → scan_ch sequence 0,1,2,3,4,0. scan_first=1 only when scan_ch=0. volumes written 0x10..0x14 = 1..5 appear matching the channel.
- Write 0x12=0x0F on the same edge that scans channel 2 → scan_volume for channel 2 is the old value. 0x0F appears on the next visit.
- Assert nreset while rdreq is outstanding and a phase_reset pulse is pending → rdvalid and phase_reset stay 0, scan_ch=0, all registers read 0 after release.

Source files
------------

// File: rtl/wts_channel_register.sv
// wts_channel_register
// Control-register file for the wave-table sound engine. It holds the
// frequency count, volume and enable bit for each of CH_NUM channels, plus
// a global mode register. The CPU reaches it over a byte-wide
// wrreq/rdreq bus. The tone generator reads it through a free-running,
// time-multiplexed channel scan.
//
// Ports
//   nreset          asynchronous reset, active low
//   clk             clock, rising edge
//   wrreq           single-cycle write strobe
//   rdreq           single-cycle read strobe
//   address         register address
//   wrdata          write data
//   rddata          read data, valid while rdvalid=1, held afterwards
//   rdvalid         one-cycle pulse, the cycle after rdreq
//   scan_en         advance the channel scan
//   scan_valid      scan outputs were updated this cycle
//   scan_ch         channel index shown on the scan outputs
//   scan_frequency  committed frequency of scan_ch
//   scan_volume     volume of scan_ch
//   scan_enable     enable bit of scan_ch
//   scan_first      scan_ch==0 while scan_valid=1
//   phase_reset     per-channel one-cycle pulse after a frequency commit
//
// Address map (c = channel index)
//   0x00+2c  frequency low byte
//   0x01+2c  frequency high bits
//   0x10+c   volume
//   0x18     enable mask
//   0x1F     mode register: bit0 ATOMIC, bit1 PRST
//   Any other address ignores writes and reads back 0xFF.
module wts_channel_register #(
  parameter int CH_NUM = 5,
  parameter int FREQ_W = 12,
  parameter int VOL_W  = 4
) (
  input  logic              nreset,
  input  logic              clk,
  input  logic              wrreq,
  input  logic              rdreq,
  input  logic [7:0]        address,
  input  logic [7:0]        wrdata,
  output logic [7:0]        rddata,
  output logic              rdvalid,
  input  logic              scan_en,
  output logic              scan_valid,
  output logic [2:0]        scan_ch,
  output logic [FREQ_W-1:0] scan_frequency,
  output logic [VOL_W-1:0]  scan_volume,
  output logic              scan_enable,
  output logic              scan_first,
  output logic [CH_NUM-1:0] phase_reset
);

  logic [FREQ_W-1:0] freq   [CH_NUM];
  logic [7:0]        shadow [CH_NUM];
  logic [VOL_W-1:0]  vol    [CH_NUM];
  logic [CH_NUM-1:0] en_mask;
  logic [1:0]        mode;
  logic [2:0]        ch_cnt;

  logic [CH_NUM-1:0] commit;
  logic [7:0]        rd_mux;
  logic [FREQ_W-1:0] sel_freq;
  logic [VOL_W-1:0]  sel_vol;
  logic              sel_en;

  // Flag the channels whose committed frequency changes on this edge.
  // A high-byte write always commits. A low-byte write commits only when
  // ATOMIC is off; otherwise it just loads the shadow.
  always_comb begin
    commit = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      if (wrreq && address == 8'(2 * c + 1))
        commit[c] = 1'b1;
      else if (wrreq && !mode[0] && address == 8'(2 * c))
        commit[c] = 1'b1;
    end
  end

  // CPU write side.
  // In atomic mode the low byte waits in the shadow until the high byte
  // arrives. The shadow is never cleared by a commit, so the same low byte
  // can be reused with several high-byte writes.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int c = 0; c < CH_NUM; c++) begin
        freq[c]   <= '0;
        shadow[c] <= '0;
        vol[c]    <= '0;
      end
      en_mask <= '0;
      mode    <= '0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (wrreq && address == 8'(2 * c)) begin
          if (mode[0])
            shadow[c] <= wrdata;
          else
            freq[c][7:0] <= wrdata;
        end
        if (wrreq && address == 8'(2 * c + 1)) begin
          if (mode[0])
            freq[c] <= {wrdata[FREQ_W-9:0], shadow[c]};
          else
            freq[c][FREQ_W-1:8] <= wrdata[FREQ_W-9:0];
        end
        if (wrreq && address == 8'(8'h10 + c))
          vol[c] <= wrdata[VOL_W-1:0];
      end
      if (wrreq && address == 8'h18)
        en_mask <= wrdata[CH_NUM-1:0];
      if (wrreq && address == 8'h1F)
        mode <= wrdata[1:0];
    end
  end

  // Read-back mux built from the current register contents. Because it
  // samples state from before the edge, a read that coincides with a
  // write to the same address returns the old value. The low byte shows
  // the committed frequency, never the shadow.
  always_comb begin
    rd_mux = 8'hFF;
    for (int c = 0; c < CH_NUM; c++) begin
      if (address == 8'(2 * c))
        rd_mux = freq[c][7:0];
      if (address == 8'(2 * c + 1))
        rd_mux = 8'(freq[c][FREQ_W-1:8]);
      if (address == 8'(8'h10 + c))
        rd_mux = 8'(vol[c]);
    end
    if (address == 8'h18)
      rd_mux = 8'(en_mask);
    if (address == 8'h1F)
      rd_mux = {6'b0, mode};
  end

  // Registered read: the data lands one cycle after rdreq and then holds.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rddata  <= '0;
      rdvalid <= 1'b0;
    end else begin
      rdvalid <= rdreq;
      if (rdreq)
        rddata <= rd_mux;
    end
  end

  // Pick the channel currently addressed by the scan counter.
  always_comb begin
    sel_freq = freq[0];
    sel_vol  = vol[0];
    sel_en   = en_mask[0];
    for (int c = 0; c < CH_NUM; c++) begin
      if (ch_cnt == 3'(c)) begin
        sel_freq = freq[c];
        sel_vol  = vol[c];
        sel_en   = en_mask[c];
      end
    end
  end

  // Channel scan. It presents the values that were committed before this
  // edge, so a commit that lands on the same edge shows up on the next
  // visit to that channel.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ch_cnt         <= '0;
      scan_ch        <= '0;
      scan_frequency <= '0;
      scan_volume    <= '0;
      scan_enable    <= 1'b0;
      scan_valid     <= 1'b0;
      scan_first     <= 1'b0;
    end else if (scan_en) begin
      scan_ch        <= ch_cnt;
      scan_frequency <= sel_freq;
      scan_volume    <= sel_vol;
      scan_enable    <= sel_en;
      scan_valid     <= 1'b1;
      scan_first     <= (ch_cnt == 3'd0);
      ch_cnt         <= (ch_cnt == 3'(CH_NUM - 1)) ? 3'd0 : ch_cnt + 3'd1;
    end else begin
      scan_valid <= 1'b0;
      scan_first <= 1'b0;
    end
  end

  // Phase-reset pulses follow each frequency commit by one cycle, but only
  // while PRST is set.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)
      phase_reset <= '0;
    else
      phase_reset <= mode[1] ? commit : '0;
  end

endmodule
